// File: rtl/intr_pkg.sv
// Shared types and helpers for the interrupt service controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package intr_pkg;

    localparam int N_SRC = 4;
    localparam int ID_W  = 2;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Index of the highest set bit; zero when nothing is set (callers qualify with |v).
    function automatic id_t highest_set(input logic [N_SRC-1:0] v);
        id_t r;
        r = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (v[i]) r = id_t'(i);
        end
        return r;
    endfunction

    // Sources of strictly higher priority than id.
    function automatic logic [N_SRC-1:0] above_mask(input id_t id);
        logic [N_SRC-1:0] m;
        for (int i = 0; i < N_SRC; i++) begin
            m[i] = (i > int'(id));
        end
        return m;
    endfunction

endpackage

// File: rtl/intr_prio_pick.sv
// Highest-priority finder over a 4-bit request vector (index 3 wins).
// Latency: purely combinational, zero cycles.
// Backpressure: none; vld simply reports whether any request bit is set.
module intr_prio_pick
    import intr_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    output logic             vld,
    output id_t              id
);

    assign vld = |req;
    assign id  = highest_set(req);

endmodule

// File: rtl/intr_service_ctrl.sv
// Interrupt service controller: latches pending sources, arbitrates, requests the CPU, tracks ack/eoi.
// Latency: pending latched in cycle N is arbitrated in N+1, irq_o visible in N+2; all outputs registered.
// Backpressure: request held until ack_i or ACK_TIMEOUT cycles, then withdrawn with a timeout_o pulse.
// Build option: define INTR_NESTING_EN to allow higher-priority sources to preempt an in-service one.
module intr_service_ctrl
    import intr_pkg::*;
#(
    parameter int               VEC_W       = 8,
    parameter logic [VEC_W-1:0] VEC_BASE    = 8'h20,
    parameter int               ACK_TIMEOUT = 15,
    parameter int               CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             intr_i,
    input  logic [1:0]       x_i,
    input  logic [3:0]       mask_i,
    input  logic             ack_i,
    input  logic             eoi_i,
    output logic             irq_o,
    output logic [VEC_W-1:0] vec_o,
    output logic [3:0]       isr_o,
    output logic [3:0]       pend_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t             state_q, state_d;
    id_t                cur_q, cur_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               tmo_q, tmo_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   isr_q, isr_d;

    logic [N_SRC-1:0]   eligible;
    logic               win_vld;
    id_t                win_id;

    assign eligible = pend_q & ~mask_i;

    intr_prio_pick u_pick (
        .req (eligible),
        .vld (win_vld),
        .id  (win_id)
    );

`ifdef INTR_NESTING_EN
    // Interrupted ids, innermost on top; at most one level per priority so depth never exceeds 3.
    logic [3:0][ID_W-1:0] stack_q, stack_d;
    logic [2:0]           depth_q, depth_d;
    logic [1:0]           top_idx;
    logic                 pre_vld;
    id_t                  pre_id;

    assign top_idx = depth_q[1:0] - 2'd1;

    intr_prio_pick u_pre_pick (
        .req (eligible & above_mask(cur_q)),
        .vld (pre_vld),
        .id  (pre_id)
    );
`endif

    // Next-state, pending/in-service update and registered-output computation.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        tmo_d   = 1'b0;
        pend_d  = pend_q;
        isr_d   = isr_q;
`ifdef INTR_NESTING_EN
        stack_d = stack_q;
        depth_d = depth_q;
`endif

        // Capture first so that an ack clear below wins over a same-cycle set.
        if (intr_i && !isr_q[x_i]) begin
            pend_d[x_i] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    cur_d   = win_id;
                    vec_d   = VEC_BASE + VEC_W'(win_id);
                    irq_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (ack_i) begin
                    pend_d[cur_q] = 1'b0;
                    isr_d[cur_q]  = 1'b1;
                    irq_d         = 1'b0;
                    state_d       = SERVICE;
                end else if (cnt_q == CNT_LAST) begin
                    irq_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
`ifdef INTR_NESTING_EN
                    // A withdrawn preemption resumes the interrupted handler.
                    if (depth_q != 3'd0) begin
                        cur_d   = stack_q[top_idx];
                        depth_d = depth_q - 3'd1;
                        state_d = SERVICE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SERVICE: begin
                if (eoi_i) begin
                    isr_d[cur_q] = 1'b0;
                    state_d      = IDLE;
`ifdef INTR_NESTING_EN
                    if (depth_q != 3'd0) begin
                        cur_d   = stack_q[top_idx];
                        depth_d = depth_q - 3'd1;
                        state_d = SERVICE;
                    end
`endif
                end
`ifdef INTR_NESTING_EN
                else if (pre_vld) begin
                    stack_d[depth_q[1:0]] = cur_q;
                    depth_d = depth_q + 3'd1;
                    cur_d   = pre_id;
                    vec_d   = VEC_BASE + VEC_W'(pre_id);
                    irq_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any request without a timeout pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            tmo_q   <= 1'b0;
            pend_q  <= '0;
            isr_q   <= '0;
`ifdef INTR_NESTING_EN
            stack_q <= '0;
            depth_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            isr_q   <= isr_d;
`ifdef INTR_NESTING_EN
            stack_q <= stack_d;
            depth_q <= depth_d;
`endif
        end
    end

    assign irq_o     = irq_q;
    assign vec_o     = vec_q;
    assign isr_o     = isr_q;
    assign pend_o    = pend_q;
    assign timeout_o = tmo_q;

endmodule

// File: tb/tb_intr_service_ctrl.sv
// Bench for intr_service_ctrl: directed literal checks plus randomized traffic against a behavioural model.
// Latency: model is compared one time unit after every rising edge.
// Backpressure: ack/eoi are randomized, including long ack droughts to provoke timeouts.
module tb_intr_service_ctrl;

    localparam int ACK_TIMEOUT = 15;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       intr_i = 1'b0;
    logic [1:0] x_i = 2'd0;
    logic [3:0] mask_i = 4'd0;
    logic       ack_i = 1'b0;
    logic       eoi_i = 1'b0;
    logic       irq_o;
    logic [7:0] vec_o;
    logic [3:0] isr_o;
    logic [3:0] pend_o;
    logic       timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    intr_service_ctrl dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .intr_i    (intr_i),
        .x_i       (x_i),
        .mask_i    (mask_i),
        .ack_i     (ack_i),
        .eoi_i     (eoi_i),
        .irq_o     (irq_o),
        .vec_o     (vec_o),
        .isr_o     (isr_o),
        .pend_o    (pend_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases: requesting (irq up, waiting for ack), serving (handler running), else idle.
    logic [3:0] m_pend, m_isr;
    logic       m_irq, m_tmo;
    logic [7:0] m_vec;
    bit         m_requesting, m_serving;
    int         m_cur, m_age, m_best;
    int         m_stk[$];

    function automatic int best_of(input logic [3:0] v);
        int b;
        b = -1;
        for (int i = 0; i < 4; i++) if (v[i]) b = i;
        return b;
    endfunction

    task automatic m_start(input int id);
        m_cur        = id;
        m_requesting = 1'b1;
        m_serving    = 1'b0;
        m_age        = 0;
        m_irq        = 1'b1;
        m_vec        = 8'(32'h20 + id);
    endtask

    // Advance the model on each rising edge, then compare against the DUT just after it.
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_pend = '0; m_isr = '0; m_irq = 1'b0; m_tmo = 1'b0; m_vec = '0;
            m_requesting = 1'b0; m_serving = 1'b0; m_cur = 0; m_age = 0;
            m_stk.delete();
        end else begin
            m_best = best_of(m_pend & ~mask_i);
            m_tmo  = 1'b0;
            if (intr_i && !m_isr[x_i]) m_pend[x_i] = 1'b1;
            if (m_requesting) begin
                if (ack_i) begin
                    m_pend[m_cur] = 1'b0;
                    m_isr[m_cur]  = 1'b1;
                    m_irq         = 1'b0;
                    m_requesting  = 1'b0;
                    m_serving     = 1'b1;
                end else begin
                    m_age++;
                    if (m_age == ACK_TIMEOUT) begin
                        m_irq        = 1'b0;
                        m_tmo        = 1'b1;
                        m_requesting = 1'b0;
                        if (m_stk.size() > 0) begin
                            m_cur     = m_stk.pop_back();
                            m_serving = 1'b1;
                        end
                    end
                end
            end else if (m_serving) begin
                if (eoi_i) begin
                    m_isr[m_cur] = 1'b0;
                    if (m_stk.size() > 0) m_cur = m_stk.pop_back();
                    else m_serving = 1'b0;
                end
`ifdef INTR_NESTING_EN
                else if (m_best > m_cur) begin
                    m_stk.push_back(m_cur);
                    m_start(m_best);
                end
`endif
            end else if (m_best >= 0) begin
                m_start(m_best);
            end
        end
        #1;
        chk("model_irq",  {31'd0, irq_o},     {31'd0, m_irq});
        chk("model_vec",  {24'd0, vec_o},     {24'd0, m_vec});
        chk("model_isr",  {28'd0, isr_o},     {28'd0, m_isr});
        chk("model_pend", {28'd0, pend_o},    {28'd0, m_pend});
        chk("model_tmo",  {31'd0, timeout_o}, {31'd0, m_tmo});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic i, input logic [1:0] x, input logic [3:0] m,
                       input logic a, input logic e);
        intr_i = i; x_i = x; mask_i = m; ack_i = a; eoi_i = e;
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int ack_pct;
        logic [3:0] msk;
        ack_pct = 30;
        msk = '0;

        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_irq",  {31'd0, irq_o},     32'd0);
        chk("rst_vec",  {24'd0, vec_o},     32'd0);
        chk("rst_isr",  {28'd0, isr_o},     32'd0);
        chk("rst_pend", {28'd0, pend_o},    32'd0);
        chk("rst_tmo",  {31'd0, timeout_o}, 32'd0);
        rst_ni = 1'b1;

        // Basic flow for source 2.
        cyc(1, 2, 4'h0, 0, 0);
        chk("t1_pend", {28'd0, pend_o}, 32'h4);
        chk("t1_irq_early", {31'd0, irq_o}, 32'd0);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t1_irq", {31'd0, irq_o}, 32'd1);
        chk("t1_vec", {24'd0, vec_o}, 32'h22);
        cyc(0, 0, 4'h0, 1, 0);
        chk("t1_ack_isr",  {28'd0, isr_o},  32'h4);
        chk("t1_ack_pend", {28'd0, pend_o}, 32'h0);
        chk("t1_ack_irq",  {31'd0, irq_o},  32'd0);
        cyc(0, 0, 4'h0, 0, 1);
        chk("t1_eoi_isr", {28'd0, isr_o}, 32'h0);

        // Priority: 1 and 3 both pending before arbitration -> 3 first.
        cyc(1, 1, 4'hF, 0, 0);
        cyc(1, 3, 4'hF, 0, 0);
        chk("t2_pend", {28'd0, pend_o}, 32'hA);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t2_vec3", {24'd0, vec_o}, 32'h23);
        cyc(0, 0, 4'h0, 1, 0);
        chk("t2_isr3", {28'd0, isr_o}, 32'h8);
        cyc(0, 0, 4'h0, 0, 1);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t2_irq1", {31'd0, irq_o}, 32'd1);
        chk("t2_vec1", {24'd0, vec_o}, 32'h21);
        cyc(0, 0, 4'h0, 1, 0);
        cyc(0, 0, 4'h0, 0, 1);

        // Masking source 3.
        cyc(1, 3, 4'hF, 0, 0);
        cyc(1, 0, 4'hF, 0, 0);
        cyc(0, 0, 4'h8, 0, 0);
        chk("t3_vec0", {24'd0, vec_o}, 32'h20);
        cyc(0, 0, 4'h8, 1, 0);
        chk("t3_pend", {28'd0, pend_o}, 32'h8);
        cyc(0, 0, 4'h8, 0, 1);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t3_irq3", {31'd0, irq_o}, 32'd1);
        chk("t3_vec3", {24'd0, vec_o}, 32'h23);
        cyc(0, 0, 4'h0, 1, 0);
        cyc(0, 0, 4'h0, 0, 1);

        // Ack timeout.
        cyc(1, 0, 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t4_irq_up", {31'd0, irq_o}, 32'd1);
        bad = 0;
        for (int k = 0; k < ACK_TIMEOUT - 1; k++) begin
            cyc(0, 0, 4'h0, 0, 0);
            if (irq_o !== 1'b1 || timeout_o !== 1'b0) bad++;
        end
        chk("t4_hold", bad, 32'd0);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t4_irq_drop", {31'd0, irq_o},     32'd0);
        chk("t4_tmo",      {31'd0, timeout_o}, 32'd1);
        chk("t4_pend",     {28'd0, pend_o},    32'h1);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t4_tmo_off",  {31'd0, timeout_o}, 32'd0);
        chk("t4_irq_back", {31'd0, irq_o},     32'd1);
        cyc(0, 0, 4'h0, 1, 0);
        cyc(0, 0, 4'h0, 0, 1);

        // Higher source arrives while source 1 is in service.
        cyc(1, 1, 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 1, 0);
        chk("t5_isr1", {28'd0, isr_o}, 32'h2);
        cyc(1, 3, 4'h0, 0, 0);
        cyc(0, 0, 4'h0, 0, 0);
`ifdef INTR_NESTING_EN
        chk("t5_pre_irq", {31'd0, irq_o}, 32'd1);
        chk("t5_pre_vec", {24'd0, vec_o}, 32'h23);
        cyc(0, 0, 4'h0, 1, 0);
        chk("t5_isr_both", {28'd0, isr_o}, 32'hA);
        cyc(0, 0, 4'h0, 0, 1);
        chk("t5_isr_back", {28'd0, isr_o}, 32'h2);
        chk("t5_irq_back", {31'd0, irq_o}, 32'd0);
        cyc(0, 0, 4'h0, 0, 1);
        chk("t5_isr_done", {28'd0, isr_o}, 32'h0);
`else
        chk("t5_no_pre", {31'd0, irq_o}, 32'd0);
        cyc(0, 0, 4'h0, 0, 1);
        chk("t5_isr_done", {28'd0, isr_o}, 32'h0);
        cyc(0, 0, 4'h0, 0, 0);
        chk("t5_irq3", {31'd0, irq_o}, 32'd1);
        chk("t5_vec3", {24'd0, vec_o}, 32'h23);
        cyc(0, 0, 4'h0, 1, 0);
        cyc(0, 0, 4'h0, 0, 1);
`endif

        // Reset while requesting, then stray ack/eoi in idle.
        cyc(1, 2, 4'h0, 0, 0);
        cyc(1, 1, 4'h0, 0, 0);
        chk("t6_irq_pre", {31'd0, irq_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_irq",  {31'd0, irq_o},     32'd0);
        chk("t6_rst_pend", {28'd0, pend_o},    32'd0);
        chk("t6_rst_isr",  {28'd0, isr_o},     32'd0);
        chk("t6_rst_tmo",  {31'd0, timeout_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(0, 0, 4'h0, 1, 1);
        chk("t6_stray_irq", {31'd0, irq_o}, 32'd0);
        chk("t6_stray_isr", {28'd0, isr_o}, 32'd0);
        cyc(0, 0, 4'h0, 0, 0);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) ack_pct = ($urandom_range(0, 1) == 1) ? 40 : 4;
            if (c % 40 == 0) msk = ($urandom_range(0, 9) < 7) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 799) == 0) begin
                rst_ni = 1'b0;
                cyc(0, 0, msk, 0, 0);
                rst_ni = 1'b1;
            end else begin
                cyc($urandom_range(0, 99) < 40,
                    2'($urandom_range(0, 3)),
                    msk,
                    irq_o ? ($urandom_range(0, 99) < ack_pct) : ($urandom_range(0, 99) < 3),
                    $urandom_range(0, 99) < 12);
            end
        end

        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
